// File: rtl/scanout_fetch.sv
`default_nettype none
// ==========================================================================
// scanout_fetch : raster-order framebuffer reader feeding a pixel FIFO with a
//                 valid/ready pixel output. SCANOUT_SCALE2_EN: 2x2 upscaling.
// Revision      : 1.0  initial release
// ==========================================================================
module scanout_fetch #(
  parameter int          IMG_W      = 100,
  parameter int          IMG_H      = 100,
  parameter logic [15:0] BASE_ADDR  = 16'h0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic        frame_done,
  output logic        underflow
);

`ifdef SCANOUT_SCALE2_EN
  localparam int c_REPS = 2;
`else
  localparam int c_REPS = 1;
`endif
  localparam int c_NRD  = c_REPS * IMG_W * IMG_H;
  localparam int c_NACC = c_REPS * c_REPS * IMG_W * IMG_H;
  localparam int c_CW   = $clog2(c_NACC + 1);
  localparam int c_AW   = $clog2(FIFO_DEPTH);
  localparam int c_CNTW = c_AW + 1;
  localparam int c_XW   = $clog2(IMG_W);
  localparam logic [c_XW-1:0]   c_XLAST = c_XW'(IMG_W - 1);
  localparam logic [c_CNTW-1:0] c_DEPTH = c_CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state, w_stateNext;
  logic              r_armed;
  logic              r_inflight;
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wrPtr, r_rdPtr;
  logic [c_CNTW-1:0] r_count;
  logic [c_XW-1:0]   r_x;
  logic [c_CW-1:0]   r_rdCnt, r_accCnt;
`ifdef SCANOUT_SCALE2_EN
  logic              r_pass;
  logic              r_rep;
`endif

  logic w_active, w_start, w_room, w_issue, w_push, w_accept, w_pop;
  logic w_lastRd, w_lastAcc, w_unusedHi;

  // A frame_start on the very first edge after reset release is ignored
  assign w_start   = frame_start && r_armed;
  assign w_active  = (r_state != S_IDLE);
  assign w_room    = (r_count + c_CNTW'(r_inflight)) < c_DEPTH;
  assign w_issue   = (r_state == S_FETCH) && w_room;
  assign w_push    = r_inflight;
  assign w_accept  = pix_valid && pix_ready;
`ifdef SCANOUT_SCALE2_EN
  assign w_pop     = w_accept && r_rep;
`else
  assign w_pop     = w_accept;
`endif
  assign w_lastRd  = w_issue && (r_rdCnt == c_CW'(c_NRD - 1));
  assign w_lastAcc = w_accept && (r_accCnt == c_CW'(c_NACC - 1));
  assign w_unusedHi = ^mem_rdata[15:8];

  assign pix_valid = (r_count != '0);
  assign pix_data  = pix_valid ? r_fifo[r_rdPtr] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_start) begin
      w_stateNext = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_stateNext = S_IDLE;
        S_FETCH: if (w_lastRd)  w_stateNext = S_DRAIN;
        S_DRAIN: if (w_lastAcc) w_stateNext = S_IDLE;
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed    <= 1'b0;
      r_inflight <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_x        <= '0;
      r_rdCnt    <= '0;
      r_accCnt   <= '0;
      mem_addr   <= BASE_ADDR;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
`ifdef SCANOUT_SCALE2_EN
      r_pass     <= 1'b0;
      r_rep      <= 1'b0;
`endif
    end else begin
      r_armed    <= 1'b1;
      frame_done <= w_lastAcc && !w_start;
      if (w_start) begin
        // Restart drops the FIFO contents and any read still in the RAM pipe
        r_inflight <= 1'b0;
        r_wrPtr    <= '0;
        r_rdPtr    <= '0;
        r_count    <= '0;
        r_x        <= '0;
        r_rdCnt    <= '0;
        r_accCnt   <= '0;
        mem_addr   <= BASE_ADDR;
        underflow  <= 1'b0;
`ifdef SCANOUT_SCALE2_EN
        r_pass     <= 1'b0;
        r_rep      <= 1'b0;
`endif
      end else begin
        if (w_active && pix_ready && !pix_valid) underflow <= 1'b1;
        r_inflight <= w_issue;
        if (w_issue) begin
          r_rdCnt <= r_rdCnt + c_CW'(1);
          if (r_x == c_XLAST) begin
            r_x <= '0;
`ifdef SCANOUT_SCALE2_EN
            // First pass over a line rewinds to its start for the repeat pass
            if (!r_pass) mem_addr <= mem_addr - 16'(IMG_W - 1);
            else         mem_addr <= mem_addr + 16'd1;
            r_pass <= ~r_pass;
`else
            mem_addr <= mem_addr + 16'd1;
`endif
          end else begin
            r_x      <= r_x + c_XW'(1);
            mem_addr <= mem_addr + 16'd1;
          end
        end
        if (w_push) r_wrPtr <= r_wrPtr + c_AW'(1);
        if (w_pop)  r_rdPtr <= r_rdPtr + c_AW'(1);
        if (w_accept) begin
          r_accCnt <= r_accCnt + c_CW'(1);
`ifdef SCANOUT_SCALE2_EN
          r_rep    <= ~r_rep;
`endif
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNTW'(1);
          2'b01:   r_count <= r_count - c_CNTW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wrPtr] <= mem_rdata[7:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_scanout_fetch.sv
`default_nettype none
// Bench for scanout_fetch: random sink back-pressure checked against a queue of
// expected pixels built directly from the framebuffer contents.
module tb_scanout_fetch;
  localparam int          W     = 4;
  localparam int          H     = 3;
  localparam logic [15:0] BASE  = 16'hFFFE;
  localparam int          DEPTH = 8;
`ifdef SCANOUT_SCALE2_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        frame_done;
  logic        underflow;

  logic [15:0] mem [0:65535];
  logic [7:0]  expQ [$];
  bit          expDone = 1'b0;
  int          nChecks = 0;
  int          nPass = 0;

  scanout_fetch #(
    .IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .frame_done(frame_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Address of the k-th read of a frame: each source line is read REP times
  function automatic logic [15:0] nthAddr(input int k);
    int y, x;
    y = k / (REP * W);
    x = k % W;
    return BASE + 16'(y * W + x);
  endfunction

  task automatic buildFrame();
    logic [15:0] a;
    expQ.delete();
    for (int y = 0; y < H; y++)
      for (int p = 0; p < REP; p++)
        for (int x = 0; x < W; x++)
          for (int r = 0; r < REP; r++) begin
            a = BASE + 16'(y * W + x);
            expQ.push_back(mem[a][7:0]);
          end
  endtask

  // One clock: check frame_done, drive inputs, score any acceptance at the next edge
  task automatic cycle(input bit rdy, input bit fs);
    @(negedge clk);
    checkEq("frame_done", frame_done, expDone);
    expDone = 1'b0;
    pix_ready = rdy;
    frame_start = fs;
    if (!fs && rdy && pix_valid) begin
      if (expQ.size() == 0) begin
        checkEq("extra_pixel", pix_valid, 0);
      end else begin
        checkEq("pix_data", pix_data, expQ.pop_front());
        if (expQ.size() == 0) expDone = 1'b1;
      end
    end
  endtask

  task automatic startFrame();
    buildFrame();
    cycle(0, 1);
    cycle(0, 0);
    checkEq("valid_n1", pix_valid, 0);
    checkEq("addr_n1", mem_addr, nthAddr(0));
    checkEq("underflow_clr", underflow, 0);
    cycle(0, 0);
    checkEq("valid_n2", pix_valid, 0);
    checkEq("addr_n2", mem_addr, nthAddr(1));
    cycle(0, 0);
    checkEq("valid_n3", pix_valid, 1);
    checkEq("addr_n3", mem_addr, nthAddr(2));
  endtask

  task automatic drainAll(input bit allReady);
    int budget;
    budget = 3000;
    while (expQ.size() != 0 && budget > 0) begin
      cycle(allReady ? 1'b1 : 1'($urandom_range(0, 1)), 0);
      budget--;
    end
    checkEq("drain_left", expQ.size(), 0);
    cycle(0, 0);
    cycle(0, 0);
    checkEq("idle_valid", pix_valid, 0);
  endtask

  initial begin
    int got;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEq("rst_addr", mem_addr, BASE);
    checkEq("rst_valid", pix_valid, 0);
    checkEq("rst_data", pix_data, 0);
    checkEq("rst_done", frame_done, 0);
    checkEq("rst_uf", underflow, 0);
    rst = 1'b1;
    repeat (3) cycle(0, 0);

    // Sink always ready once pixels appear
    startFrame();
    drainAll(1);
    checkEq("uf_ready", underflow, 0);

    // Back-pressure: fetch stops with the FIFO plus in-flight read full
    startFrame();
    cycle(0, 0);
    checkEq("addr_wrap", mem_addr, nthAddr(3));
    repeat (20) cycle(0, 0);
    checkEq("addr_stall", mem_addr, nthAddr(DEPTH));
    checkEq("valid_stall", pix_valid, 1);
    drainAll(0);
    checkEq("uf_stall", underflow, 0);

    // Restart after five pixels: FIFO flushed, no frame_done for the abandoned frame
    startFrame();
    got = expQ.size();
    for (int b = 0; b < 200 && (got - expQ.size()) < 5; b++) cycle(1, 0);
    checkEq("restart_pre", got - expQ.size(), 5);
    startFrame();
    drainAll(1);
    checkEq("uf_restart", underflow, 0);

    // Sink ready before any data: sticky underflow until next frame_start
    buildFrame();
    cycle(0, 1);
    cycle(1, 0);
    cycle(1, 0);
    checkEq("uf_set", underflow, 1);
    drainAll(1);
    repeat (4) cycle(0, 0);
    checkEq("uf_held", underflow, 1);
    startFrame();

    // Asynchronous reset in the middle of a frame with underflow raised
    cycle(0, 0);
    cycle(1, 0);
    cycle(1, 0);
    repeat (3) cycle(1, 0);
    checkEq("uf_mid", underflow, 0);
    buildFrame();
    cycle(0, 1);
    cycle(0, 0);
    cycle(1, 0);
    cycle(1, 0);
    repeat (3) cycle(1, 0);
    checkEq("uf_pre_rst", underflow, 1);
    @(negedge clk);
    pix_ready = 1'b0;
    rst = 1'b0;
    #1;
    checkEq("mid_rst_addr", mem_addr, BASE);
    checkEq("mid_rst_valid", pix_valid, 0);
    checkEq("mid_rst_data", pix_data, 0);
    checkEq("mid_rst_done", frame_done, 0);
    checkEq("mid_rst_uf", underflow, 0);
    expQ.delete();
    expDone = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cycle(0, 0);
    checkEq("post_rst_valid", pix_valid, 0);
    checkEq("post_rst_addr", mem_addr, BASE);

    // Random back-pressure frames
    for (int f = 0; f < 3; f++) begin
      startFrame();
      drainAll(0);
      checkEq("uf_rand", underflow, 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
`default_nettype wire
